// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// A power-up sweep clears the valid bits one entry per cycle before predictions are enabled.
module btb_predictor #(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] lookup_pc_i,
   output logic        pred_hit_o,
   output logic        pred_taken_o,
   output logic [31:0] pred_target_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic [31:0] upd_target_i,
   input  logic        upd_taken_i,
   input  logic        upd_is_branch_i,
   output logic        init_done_o
);

   localparam int unsigned TAG_W = 30 - IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e           state_q;
   state_e           state_d;
   logic [IDX_W-1:0] sweep_q;
   logic [IDX_W-1:0] sweep_d;
   logic             ready_c;

   logic             valid_q     [ENTRIES];
   logic [TAG_W-1:0] tag_q       [ENTRIES];
   logic [31:0]      target_q    [ENTRIES];
   logic             is_branch_q [ENTRIES];
   logic [1:0]       ctr_q       [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit_c;
   logic             lk_taken_c;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit_c;
   logic [1:0]       ctr_upd_c;
   logic             unused_pc_bits;

   assign lk_idx  = lookup_pc_i[IDX_W+1:2];
   assign lk_tag  = lookup_pc_i[31:IDX_W+2];
   assign upd_idx = upd_pc_i[IDX_W+1:2];
   assign upd_tag = upd_pc_i[31:IDX_W+2];

   // Update PCs are word aligned; the byte offset carries no information.
   assign unused_pc_bits = ^upd_pc_i[1:0];

   // State register and sweep index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // Next state: sweep every entry once, then stay ready until reset
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      unique case (state_q)
         ST_INIT: begin
            sweep_d = sweep_q + IDX_W'(1);
            if (sweep_q == LAST_IDX) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      ready_c     = 1'b0;
      init_done_o = 1'b0;
      if (state_q == ST_READY) begin
         ready_c     = 1'b1;
         init_done_o = 1'b1;
      end
   end

   // Zero-latency lookup; falls through to the sequential PC on miss or not-taken
   always_comb begin
      lk_hit_c      = 1'b0;
      lk_taken_c    = 1'b0;
      pred_target_o = lookup_pc_i + 32'd4;
      if (ready_c && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
         lk_hit_c   = 1'b1;
         lk_taken_c = is_branch_q[lk_idx] ? ctr_q[lk_idx][1] : 1'b1;
      end
      if (lk_taken_c) begin
         pred_target_o = target_q[lk_idx];
      end
      pred_hit_o   = lk_hit_c;
      pred_taken_o = lk_taken_c;
   end

   // Saturating counter step for the entry being updated
   always_comb begin
      upd_hit_c = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      ctr_upd_c = ctr_q[upd_idx];
      if (upd_taken_i) begin
         if (ctr_q[upd_idx] != 2'b11) begin
            ctr_upd_c = ctr_q[upd_idx] + 2'd1;
         end
      end else if (ctr_q[upd_idx] != 2'b00) begin
         ctr_upd_c = ctr_q[upd_idx] - 2'd1;
      end
   end

   // Table write port: sweep clear during INIT, resolved-branch training once ready
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (!ready_c) begin
            valid_q[sweep_q] <= 1'b0;
         end else if (upd_valid_i) begin
            if (upd_hit_c) begin
               ctr_q[upd_idx]       <= ctr_upd_c;
               is_branch_q[upd_idx] <= upd_is_branch_i;
               if (upd_taken_i) begin
                  target_q[upd_idx] <= upd_target_i;
               end
            end else if (upd_taken_i) begin
               valid_q[upd_idx]     <= 1'b1;
               tag_q[upd_idx]       <= upd_tag;
               target_q[upd_idx]    <= upd_target_i;
               is_branch_q[upd_idx] <= upd_is_branch_i;
               ctr_q[upd_idx]       <= upd_is_branch_i ? 2'b10 : 2'b11;
            end
         end
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed scenarios plus randomized traffic checked against
// a table-level model of the BTB (per-entry records, plain integer counters).
module tb_btb_predictor;

   localparam int unsigned ENTRIES = 64;
   localparam int unsigned IDX_W   = 6;
   localparam int unsigned TAG_W   = 30 - IDX_W;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lookup_pc;
   logic        pred_hit_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_is_branch;
   logic        init_done_o;

   always #5 clk = ~clk;

   btb_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lookup_pc_i    (lookup_pc),
      .pred_hit_o     (pred_hit_o),
      .pred_taken_o   (pred_taken_o),
      .pred_target_o  (pred_target_o),
      .upd_valid_i    (upd_valid),
      .upd_pc_i       (upd_pc),
      .upd_target_i   (upd_target),
      .upd_taken_i    (upd_taken),
      .upd_is_branch_i(upd_is_branch),
      .init_done_o    (init_done_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one record per entry, readiness = cycles since reset release
   bit               m_valid  [ENTRIES];
   logic [TAG_W-1:0] m_tag    [ENTRIES];
   logic [31:0]      m_target [ENTRIES];
   bit               m_isbr   [ENTRIES];
   int               m_ctr    [ENTRIES];
   int               m_since_rst = 0;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
      return TAG_W'(pc >> (IDX_W + 2));
   endfunction

   function automatic void model_predict(input logic [31:0] pc, output logic hit,
                                         output logic taken, output logic [31:0] tgt);
      int i;
      i     = idx_of(pc);
      hit   = (m_since_rst >= int'(ENTRIES)) && m_valid[i] && (m_tag[i] == tag_of(pc));
      taken = hit && (!m_isbr[i] || (m_ctr[i] >= 2));
      tgt   = taken ? m_target[i] : pc + 32'd4;
   endfunction

   function automatic void model_update(input logic [31:0] pc, input logic [31:0] tgt,
                                        input logic taken, input logic isbr);
      int i;
      i = idx_of(pc);
      if (m_valid[i] && (m_tag[i] == tag_of(pc))) begin
         m_ctr[i]  = taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                           : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
         m_isbr[i] = isbr;
         if (taken) m_target[i] = tgt;
      end else if (taken) begin
         m_valid[i]  = 1'b1;
         m_tag[i]    = tag_of(pc);
         m_target[i] = tgt;
         m_isbr[i]   = isbr;
         m_ctr[i]    = isbr ? 2 : 3;
      end
   endfunction

   // Advance one clock; the model consumes the same inputs the DUT sees at the edge
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m_since_rst = 0;
         foreach (m_valid[i]) m_valid[i] = 1'b0;
      end else begin
         if ((m_since_rst >= int'(ENTRIES)) && upd_valid)
            model_update(upd_pc, upd_target, upd_taken, upd_is_branch);
         m_since_rst++;
      end
      #1;
   endtask

   task automatic drive_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic taken, input logic isbr);
      upd_valid     = v;
      upd_pc        = pc;
      upd_target    = tgt;
      upd_taken     = taken;
      upd_is_branch = isbr;
   endtask

   // Counts cycles from reset release until init_done; pulses training traffic meanwhile
   task automatic run_sweep(output int cnt, output bit init_bad);
      cnt      = 0;
      init_bad = 1'b0;
      while (!init_done_o && cnt < 200) begin
         drive_upd(1'b1, 32'h100, 32'h200, 1'b1, 1'b1);
         lookup_pc = 32'h100;
         #1;
         if (pred_hit_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h104)
            init_bad = 1'b1;
         tick();
         cnt++;
      end
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      int  cnt;
      bit  bad;
      rst_n = 1'b0;
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      lookup_pc = 32'hFFFF_FFFC;
      tick();
      tick();
      checks++;
      if ({init_done_o, pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_outputs: got done=%b hit=%b taken=%b tgt=%h, want 0 0 0 00000000",
                  init_done_o, pred_hit_o, pred_taken_o, pred_target_o);
      end
      rst_n = 1'b1;
      run_sweep(cnt, bad);
      checks++;
      if (cnt !== 64) begin
         errors++;
         $display("FAIL sweep_length: got %0d cycles, want 64", cnt);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL init_outputs: got a hit/taken/target deviation during INIT, want none");
      end
      lookup_pc = 32'h100;
      #1;
      checks++;
      if ({init_done_o, pred_hit_o, pred_target_o} !== {1'b1, 1'b0, 32'h104}) begin
         errors++;
         $display("FAIL init_updates_ignored: got done=%b hit=%b tgt=%h, want 1 0 00000104",
                  init_done_o, pred_hit_o, pred_target_o);
      end
   endtask

   task automatic test_alloc_and_counter();
      drive_upd(1'b1, 32'h100, 32'h200, 1'b1, 1'b1);
      tick();
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      lookup_pc = 32'h102;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h200}) begin
         errors++;
         $display("FAIL alloc_branch: got %b %b %h, want 1 1 00000200", pred_hit_o, pred_taken_o, pred_target_o);
      end
      for (int k = 0; k < 2; k++) begin
         drive_upd(1'b1, 32'h100, 32'hDEAD_BEE0, 1'b0, 1'b1);
         tick();
      end
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      lookup_pc = 32'h100;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b0, 32'h104}) begin
         errors++;
         $display("FAIL ctr_down: got %b %b %h, want 1 0 00000104", pred_hit_o, pred_taken_o, pred_target_o);
      end
      for (int k = 0; k < 3; k++) begin
         drive_upd(1'b1, 32'h100, 32'h200, 1'b1, 1'b1);
         tick();
      end
      drive_upd(1'b1, 32'h100, 32'hDEAD_BEE0, 1'b0, 1'b1);
      tick();
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h200}) begin
         errors++;
         $display("FAIL ctr_saturate: got %b %b %h, want 1 1 00000200", pred_hit_o, pred_taken_o, pred_target_o);
      end
   endtask

   task automatic test_alias();
      drive_upd(1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
      tick();
      drive_upd(1'b1, 32'h140, 32'h300, 1'b1, 1'b1);
      lookup_pc = 32'h40;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h80}) begin
         errors++;
         $display("FAIL jump_alloc: got %b %b %h, want 1 1 00000080", pred_hit_o, pred_taken_o, pred_target_o);
      end
      tick();
      drive_upd(1'b1, 32'h40, 32'h999C, 1'b0, 1'b0);
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h44}) begin
         errors++;
         $display("FAIL alias_evict: got %b %b %h, want 0 0 00000044", pred_hit_o, pred_taken_o, pred_target_o);
      end
      tick();
      drive_upd(1'b1, 32'h140, 32'h777C, 1'b0, 1'b0);
      lookup_pc = 32'h140;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h300}) begin
         errors++;
         $display("FAIL alias_kept: got %b %b %h, want 1 1 00000300", pred_hit_o, pred_taken_o, pred_target_o);
      end
      tick();
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h300}) begin
         errors++;
         $display("FAIL kind_rewrite: got %b %b %h, want 1 1 00000300", pred_hit_o, pred_taken_o, pred_target_o);
      end
   endtask

   task automatic test_back_to_back();
      drive_upd(1'b1, 32'h500, 32'h600, 1'b0, 1'b1);
      tick();
      drive_upd(1'b1, 32'h100, 32'h0, 1'b0, 1'b1);
      lookup_pc = 32'h500;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h504}) begin
         errors++;
         $display("FAIL nt_miss: got %b %b %h, want 0 0 00000504", pred_hit_o, pred_taken_o, pred_target_o);
      end
      lookup_pc = 32'h100;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h200}) begin
         errors++;
         $display("FAIL no_bypass: got %b %b %h, want 1 1 00000200", pred_hit_o, pred_taken_o, pred_target_o);
      end
      tick();
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b0, 32'h104}) begin
         errors++;
         $display("FAIL next_cycle_visible: got %b %b %h, want 1 0 00000104", pred_hit_o, pred_taken_o, pred_target_o);
      end
      lookup_pc = 32'hFFFF_FFFC;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL pc_wrap: got %b %b %h, want 0 0 00000000", pred_hit_o, pred_taken_o, pred_target_o);
      end
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] pc;
      if ($urandom_range(0, 9) == 0) begin
         pc = $urandom();
      end else begin
         pc = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2)
              | 32'($urandom_range(0, 3));
      end
      return pc;
   endfunction

   task automatic test_random();
      logic        eh;
      logic        et;
      logic [31:0] etg;
      int          bad = 0;
      for (int n = 0; n < 600; n++) begin
         drive_upd($urandom_range(0, 3) != 0, rand_pc(), $urandom(),
                   $urandom_range(0, 9) < 6, $urandom_range(0, 2) != 0);
         lookup_pc = ($urandom_range(0, 1) == 1) ? upd_pc : rand_pc();
         #1;
         model_predict(lookup_pc, eh, et, etg);
         checks++;
         if ({pred_hit_o, pred_taken_o, pred_target_o} !== {eh, et, etg}) begin
            errors++;
            if (bad < 10)
               $display("FAIL random_lookup pc=%h: got %b %b %h, want %b %b %h", lookup_pc,
                        pred_hit_o, pred_taken_o, pred_target_o, eh, et, etg);
            bad++;
         end
         tick();
      end
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_mid_reset();
      int cnt;
      bit bad;
      drive_upd(1'b1, 32'h100, 32'h200, 1'b1, 1'b0);
      tick();
      drive_upd(1'b1, 32'h244, 32'h400, 1'b1, 1'b1);
      tick();
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run_sweep(cnt, bad);
      checks++;
      if (cnt !== 64 || bad) begin
         errors++;
         $display("FAIL ready_reset_sweep: got %0d cycles bad=%b, want 64 bad=0", cnt, bad);
      end
      lookup_pc = 32'h244;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h248}) begin
         errors++;
         $display("FAIL ready_reset_cleared: got %b %b %h, want 0 0 00000248", pred_hit_o, pred_taken_o, pred_target_o);
      end
      drive_upd(1'b1, 32'h100, 32'h200, 1'b1, 1'b0);
      tick();
      drive_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run_sweep(cnt, bad);
      checks++;
      if (cnt !== 64 || bad) begin
         errors++;
         $display("FAIL mid_sweep_reset: got %0d cycles bad=%b, want 64 bad=0", cnt, bad);
      end
      lookup_pc = 32'h100;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h104}) begin
         errors++;
         $display("FAIL mid_reset_cleared: got %b %b %h, want 0 0 00000104", pred_hit_o, pred_taken_o, pred_target_o);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alloc_and_counter();
      test_alias();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
